// File: rtl/msadc_result_calc.sv
// Multi-slope ADC result calculator: combine counts, subtract zero, average.
// Define MSADC_SATURATE_EN to clamp the result instead of wrapping it.
module msadc_result_calc #(
  parameter int AVG_LOG2 = 0,
  parameter int RESULT_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sample_stb,
  input  logic                is_zero,
  input  logic [31:0]         pwm_na,
  input  logic [31:0]         pwm_nb,
  input  logic [31:0]         pwm_pa,
  input  logic [31:0]         pwm_pb,
  input  logic [11:0]         rundown,
  input  logic [7:0]          n64,
  input  logic [7:0]          p8,
  input  logic [7:0]          n1,
  output logic [RESULT_W-1:0] result,
  output logic                result_valid,
  input  logic                result_ready,
  output logic                zero_valid,
  output logic                overrun,
  input  logic                ovr_clr
);

  localparam int AW = 48 + AVG_LOG2;
  localparam int CW = AVG_LOG2 + 1;
  localparam logic [CW-1:0] NBLK = CW'(1) << AVG_LOG2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUNUP,
    S_RESID,
    S_ACC,
    S_OUT
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [31:0] r_na, r_nb, r_pa, r_pb;
  logic [11:0] r_rd;
  logic [7:0]  r_n64, r_p8, r_n1;
  logic        r_is_zero;

  logic signed [47:0]   r_sum;
  logic signed [47:0]   r_zero;
  logic signed [AW-1:0] r_acc;
  logic [CW-1:0]        r_cnt;

  logic signed [47:0]   w_pos, w_neg, w_runup, w_resid, w_dev;
  logic signed [AW-1:0] w_dev_ext;
  logic [CW-1:0]        w_cnt_nxt;
  logic                 w_last;
  logic                 w_load;
  logic [RESULT_W-1:0]  w_res;

  // Mode B runs at half the reference weight of mode A.
  assign w_pos = ({16'd0, r_pa} << 1) + {16'd0, r_pb};
  assign w_neg = ({16'd0, r_na} << 1) + {16'd0, r_nb};
  assign w_runup = (w_pos - w_neg) <<< 8;
  assign w_resid = {27'd0, r_rd, 9'd0}
                 - {34'd0, r_n64, 6'd0}
                 + {37'd0, r_p8, 3'd0}
                 - {40'd0, r_n1};

  assign w_dev     = r_sum - r_zero;
  assign w_dev_ext = AW'(w_dev);
  assign w_cnt_nxt = r_cnt + CW'(1);
  assign w_last    = (w_cnt_nxt == NBLK);

`ifdef MSADC_SATURATE_EN
  localparam logic signed [AW-1:0] SMAX =
    {{(AW-RESULT_W+1){1'b0}}, {(RESULT_W-1){1'b1}}};
  localparam logic signed [AW-1:0] SMIN =
    {{(AW-RESULT_W+1){1'b1}}, {(RESULT_W-1){1'b0}}};
  logic signed [AW-1:0] w_shift;
  assign w_shift = r_acc >>> AVG_LOG2;

  always_comb begin
    w_res = w_shift[RESULT_W-1:0];
    if (w_shift > SMAX) begin
      w_res = {1'b0, {(RESULT_W-1){1'b1}}};
    end else if (w_shift < SMIN) begin
      w_res = {1'b1, {(RESULT_W-1){1'b0}}};
    end
  end
`else
  assign w_res = RESULT_W'(r_acc >>> AVG_LOG2);
`endif

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    unique case (r_state)
      S_IDLE:  if (sample_stb) w_next = S_RUNUP;
      S_RUNUP: w_next = S_RESID;
      S_RESID: w_next = S_ACC;
      S_ACC: begin
        if (!r_is_zero && w_last) w_next = S_OUT;
        else                      w_next = S_IDLE;
      end
      S_OUT: begin
        w_load = !result_valid || result_ready;
        if (w_load) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      result       <= '0;
      result_valid <= 1'b0;
      zero_valid   <= 1'b0;
      overrun      <= 1'b0;
      r_zero       <= '0;
      r_acc        <= '0;
      r_cnt        <= '0;
      r_sum        <= '0;
    end else begin
      // A drop in the same cycle as a clear must stay visible.
      if (sample_stb && r_state != S_IDLE) overrun <= 1'b1;
      else if (ovr_clr)                    overrun <= 1'b0;

      if (w_load)            result_valid <= 1'b1;
      else if (result_ready) result_valid <= 1'b0;

      unique case (r_state)
        S_IDLE: begin
          if (sample_stb) begin
            r_na      <= pwm_na;
            r_nb      <= pwm_nb;
            r_pa      <= pwm_pa;
            r_pb      <= pwm_pb;
            r_rd      <= rundown;
            r_n64     <= n64;
            r_p8      <= p8;
            r_n1      <= n1;
            r_is_zero <= is_zero;
          end
        end
        S_RUNUP: r_sum <= w_runup;
        S_RESID: r_sum <= r_sum + w_resid;
        S_ACC: begin
          if (r_is_zero) begin
            r_zero     <= r_sum;
            zero_valid <= 1'b1;
          end else begin
            r_acc <= r_acc + w_dev_ext;
            r_cnt <= w_cnt_nxt;
          end
        end
        S_OUT: begin
          if (w_load) begin
            result <= w_res;
            r_acc  <= '0;
            r_cnt  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_msadc_result_calc.sv
// Scoreboard bench for msadc_result_calc: three instances
// (AVG_LOG2=0/W32, AVG_LOG2=2/W32, AVG_LOG2=0/W16) share one stimulus.
module tb_msadc_result_calc;

`ifdef MSADC_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct {
    logic [31:0] pa, pb, na, nb;
    logic [11:0] rd;
    logic [7:0]  n64, p8, n1;
  } cnt_t;

  logic clk = 1'b0;
  logic rst, stb, isz, ovr_clr;
  logic [31:0] pwm_na, pwm_nb, pwm_pa, pwm_pb;
  logic [11:0] rundown;
  logic [7:0]  n64, p8, n1;
  logic rdy0, rdy2, rdy16;
  logic [31:0] res0, res2;
  logic [15:0] res16;
  logic v0, v2, v16, zv0, zv2, zv16, ov0, ov2, ov16;

  int n_vec = 0;
  int n_err = 0;
  longint q0[$];
  longint q2[$];
  longint q16[$];

  always #5 clk = ~clk;

  msadc_result_calc #(.AVG_LOG2(0), .RESULT_W(32)) u_d0 (
    .clk(clk), .rst(rst), .sample_stb(stb), .is_zero(isz),
    .pwm_na(pwm_na), .pwm_nb(pwm_nb),
    .pwm_pa(pwm_pa), .pwm_pb(pwm_pb),
    .rundown(rundown), .n64(n64), .p8(p8), .n1(n1),
    .result(res0), .result_valid(v0), .result_ready(rdy0),
    .zero_valid(zv0), .overrun(ov0), .ovr_clr(ovr_clr)
  );

  msadc_result_calc #(.AVG_LOG2(2), .RESULT_W(32)) u_d2 (
    .clk(clk), .rst(rst), .sample_stb(stb), .is_zero(isz),
    .pwm_na(pwm_na), .pwm_nb(pwm_nb),
    .pwm_pa(pwm_pa), .pwm_pb(pwm_pb),
    .rundown(rundown), .n64(n64), .p8(p8), .n1(n1),
    .result(res2), .result_valid(v2), .result_ready(rdy2),
    .zero_valid(zv2), .overrun(ov2), .ovr_clr(ovr_clr)
  );

  msadc_result_calc #(.AVG_LOG2(0), .RESULT_W(16)) u_d16 (
    .clk(clk), .rst(rst), .sample_stb(stb), .is_zero(isz),
    .pwm_na(pwm_na), .pwm_nb(pwm_nb),
    .pwm_pa(pwm_pa), .pwm_pb(pwm_pb),
    .rundown(rundown), .n64(n64), .p8(p8), .n1(n1),
    .result(res16), .result_valid(v16), .result_ready(rdy16),
    .zero_valid(zv16), .overrun(ov16), .ovr_clr(ovr_clr)
  );

  function automatic cnt_t mk(int pa, int pb, int na, int nb,
                              int rd, int a64, int a8, int a1);
    cnt_t c;
    c.pa = pa; c.pb = pb; c.na = na; c.nb = nb;
    c.rd = 12'(rd); c.n64 = 8'(a64); c.p8 = 8'(a8); c.n1 = 8'(a1);
    return c;
  endfunction

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (rst) begin
        if (v0 && rdy0) begin
          if (q0.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL res0 unexpected: got %0d expected none",
                     $signed(res0));
          end else chk("res0", $signed(res0), q0.pop_front());
        end
        if (v2 && rdy2) begin
          if (q2.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL res2 unexpected: got %0d expected none",
                     $signed(res2));
          end else chk("res2", $signed(res2), q2.pop_front());
        end
        if (v16 && rdy16) begin
          if (q16.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL res16 unexpected: got %0d expected none",
                     $signed(res16));
          end else chk("res16", $signed(res16), q16.pop_front());
        end
      end
    end
  endtask

  task automatic expect_out(input bit o0, input longint e0,
                            input longint e16, input bit o2,
                            input longint e2);
    if (o0) begin
      q0.push_back(e0);
      q16.push_back(e16);
    end
    if (o2) q2.push_back(e2);
  endtask

  // Leaves the caller 1 time unit after the capturing edge.
  task automatic strobe(input cnt_t c, input bit z);
    @(posedge clk); #1;
    pwm_pa = c.pa; pwm_pb = c.pb; pwm_na = c.na; pwm_nb = c.nb;
    rundown = c.rd; n64 = c.n64; p8 = c.p8; n1 = c.n1;
    isz = z; stb = 1'b1;
    @(posedge clk); #1;
    stb = 1'b0; isz = 1'b0;
  endtask

  task automatic send(input cnt_t c, input bit z, input bit o0,
                      input longint e0, input longint e16,
                      input bit o2, input longint e2);
    expect_out(o0, e0, e16, o2, e2);
    strobe(c, z);
    repeat (6) @(posedge clk);
  endtask

  task automatic drop_seq(input cnt_t c, input longint e0,
                          input bit clr, input string nm);
    expect_out(1'b1, e0, e0, 1'b0, 0);
    strobe(c, 1'b0);
    @(posedge clk); #1;
    stb = 1'b1; ovr_clr = clr;
    @(posedge clk); #1;
    stb = 1'b0; ovr_clr = 1'b0;
    @(negedge clk);
    chk({nm, "_ov0"}, ov0, 1);
    chk({nm, "_ov2"}, ov2, 1);
    chk({nm, "_ov16"}, ov16, 1);
    repeat (5) @(posedge clk);
  endtask

  cnt_t V100, V200, V300, V401, VP40K, VN40K;
  cnt_t V1, V1B, VZ, VC, VD, VPB;

  initial begin
    V100  = mk(0, 0, 0, 0, 0, 0, 13, 4);
    V200  = mk(0, 0, 0, 0, 0, 0, 25, 0);
    V300  = mk(0, 0, 0, 0, 0, 0, 38, 4);
    V401  = mk(0, 0, 0, 0, 1, 2, 3, 7);
    VP40K = mk(78, 0, 0, 0, 0, 0, 8, 0);
    VN40K = mk(0, 0, 78, 0, 0, 1, 0, 0);
    V1    = mk(100, 0, 90, 0, 3, 2, 5, 7);
    V1B   = mk(101, 0, 90, 0, 3, 2, 5, 7);
    VZ    = mk(0, 0, 0, 0, 0, 0, 0, 0);
    VC    = mk(0, 0, 0, 0, 0, 0, 0, 3);
    VD    = mk(0, 0, 0, 0, 0, 0, 0, 1);
    VPB   = mk(10, 3, 5, 20, 0, 0, 0, 0);

    rst = 1'b0; stb = 1'b0; isz = 1'b0; ovr_clr = 1'b0;
    pwm_na = '0; pwm_nb = '0; pwm_pa = '0; pwm_pb = '0;
    rundown = '0; n64 = '0; p8 = '0; n1 = '0;
    rdy0 = 1'b1; rdy2 = 1'b1; rdy16 = 1'b1;

    fork
      monitor();
    join_none

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_res0", res0, 0);
    chk("rst_v0", v0, 0);
    chk("rst_zv0", zv0, 0);
    chk("rst_ov0", ov0, 0);
    @(posedge clk); #1 rst = 1'b1;

    // First sample: valid rises on the 4th edge after the strobe.
    expect_out(1'b1, 100, 100, 1'b0, 0);
    strobe(V100, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("lat_early_v0", v0, 0);
    @(posedge clk);
    @(negedge clk);
    chk("lat_v0", v0, 1);
    repeat (3) @(posedge clk);

    send(V200, 1'b0, 1'b1, 200, 200, 1'b0, 0);
    send(V300, 1'b0, 1'b1, 300, 300, 1'b0, 0);
    send(V401, 1'b0, 1'b1, 401, 401, 1'b1, 250);
    send(VP40K, 1'b0, 1'b1, 40000,
         SAT ? 32767 : -25536, 1'b0, 0);
    send(VN40K, 1'b0, 1'b1, -40000,
         SAT ? -32768 : 25536, 1'b0, 0);
    send(V1, 1'b0, 1'b1, 6561, 6561, 1'b0, 0);

    // Zero calibration: no output, flag only.
    send(V1, 1'b1, 1'b0, 0, 0, 1'b0, 0);
    @(negedge clk);
    chk("zero_v0", v0, 0);
    chk("zero_zv0", zv0, 1);
    chk("zero_zv2", zv2, 1);
    chk("zero_zv16", zv16, 1);
    send(V1B, 1'b0, 1'b1, 512, 512, 1'b1, 1768);

    // Back-pressure on instance 0.
    rdy0 = 1'b0;
    send(VZ, 1'b0, 1'b1, -6561, -6561, 1'b0, 0);
    send(V1B, 1'b0, 1'b1, 512, 512, 1'b0, 0);
    @(negedge clk);
    chk("stall_res0", $signed(res0), -6561);
    chk("stall_v0", v0, 1);
    @(posedge clk); #1 rdy0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("reload_res0", $signed(res0), 512);
    chk("reload_v0", v0, 1);
    repeat (3) @(posedge clk);

    send(VC, 1'b0, 1'b1, -6564, -6564, 1'b0, 0);
    send(VD, 1'b0, 1'b1, -6562, -6562, 1'b1, -4794);

    // Overrun: drop, drop coinciding with clear, then plain clear.
    drop_seq(VZ, -6561, 1'b0, "drop");
    drop_seq(VZ, -6561, 1'b1, "dropclr");
    @(posedge clk); #1 ovr_clr = 1'b1;
    @(posedge clk); #1 ovr_clr = 1'b0;
    @(negedge clk);
    chk("clr_ov0", ov0, 0);
    chk("clr_ov2", ov2, 0);
    chk("clr_ov16", ov16, 0);
    drop_seq(VZ, -6561, 1'b0, "drop2");

    // Reset while the calculation sits in RESID.
    strobe(V1, 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("mrst_res0", res0, 0);
    chk("mrst_res2", res2, 0);
    chk("mrst_res16", res16, 0);
    chk("mrst_v0", v0, 0);
    chk("mrst_zv0", zv0, 0);
    chk("mrst_zv2", zv2, 0);
    chk("mrst_ov0", ov0, 0);
    chk("mrst_ov16", ov16, 0);
    repeat (3) @(posedge clk);

    send(V1, 1'b0, 1'b1, 6561, 6561, 1'b0, 0);
    send(V100, 1'b0, 1'b1, 100, 100, 1'b0, 0);
    send(V200, 1'b0, 1'b1, 200, 200, 1'b0, 0);
    send(V300, 1'b0, 1'b1, 300, 300, 1'b1, 1790);
    send(VPB, 1'b0, 1'b1, -1792, -1792, 1'b0, 0);

    repeat (5) @(posedge clk);
    chk("q0_left", q0.size(), 0);
    chk("q2_left", q2.size(), 0);
    chk("q16_left", q16.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
